// File: rtl/nco_phase_gen.sv
// -----------------------------------------------------------------------------
// nco_phase_gen
//
// Phase accumulator for a numerically controlled oscillator. Each cycle with
// en=1 (and clr=0) emits one binary angle sample one cycle later and advances
// the accumulator by the active frequency control word. A new FCW/offset pair
// is staged in shadow registers and only becomes active on the next advancing
// cycle, so the downstream sine/cosine stage never sees a torn configuration.
//
// Parameters
//   ACC_WIDTH  phase accumulator width (default 32)
//   A_width    output angle width, must not exceed ACC_WIDTH (default 16)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   advance strobe, one sample per en=1 cycle
//   clr          in   synchronous clear of accumulator and output state
//   cfg_valid    in   configuration offered
//   cfg_ready    out  configuration can be accepted (= not pending)
//   cfg_fcw      in   frequency control word (unsigned phase increment)
//   cfg_poff     in   phase offset added to the output angle
//   angle_A      out  binary angle, full scale = 2*pi
//   angle_valid  out  angle_A holds a new sample this cycle
//   wrap         out  the add that produced this sample carried out
//   wrap_cnt     out  accumulator wrap count, modulo 2^16
//   cfg_state    out  config FSM state (0 = READY, 1 = PENDING)
//
// Config handshake: a configuration transfers on a rising edge where
// cfg_valid=1 and cfg_ready=1. cfg_ready depends only on internal state, never
// on cfg_valid. While cfg_ready=0 the offered fcw/poff are ignored and the
// source must keep (or re-offer) them later.
// -----------------------------------------------------------------------------
module nco_phase_gen #(
    parameter int ACC_WIDTH = 32,
    parameter int A_width   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_fcw,
    input  logic [A_width-1:0]   cfg_poff,
    output logic [A_width-1:0]   angle_A,
    output logic                 angle_valid,
    output logic                 wrap,
    output logic [15:0]          wrap_cnt,
    output logic                 cfg_state
);

    // The angle is the top slice of the accumulator, so it cannot be wider.
    if (A_width > ACC_WIDTH) begin : g_width_check
        $error("nco_phase_gen: A_width (%0d) exceeds ACC_WIDTH (%0d)", A_width, ACC_WIDTH);
    end

    // -------------------------------------------------------------------------
    // Config FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_READY   = 1'b0,
        ST_PENDING = 1'b1
    } cfg_state_e;

    cfg_state_e state_q, state_d;

    logic capture;   // shadow registers load this cycle
    logic apply;     // shadow becomes active this cycle

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. clr deliberately does not touch the FSM: a pending
    // config survives a clear and lands on the next real advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: begin
                if (cfg_valid) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (en && !clr) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // Output logic
    always_comb begin
        cfg_ready = 1'b0;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state_q)
            ST_READY: begin
                cfg_ready = 1'b1;
                capture   = cfg_valid;
            end
            ST_PENDING: begin
                apply = en && !clr;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    assign cfg_state = state_q;

    // -------------------------------------------------------------------------
    // Configuration registers
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] shadow_fcw_q, shadow_fcw_d;
    logic [A_width-1:0]   shadow_poff_q, shadow_poff_d;
    logic [ACC_WIDTH-1:0] fcw_act_q, fcw_act_d;
    logic [A_width-1:0]   poff_act_q, poff_act_d;

    // Values used by this cycle's add/output. On the apply cycle the shadow
    // is used directly so the new word takes effect without a bubble.
    logic [ACC_WIDTH-1:0] fcw_eff;
    logic [A_width-1:0]   poff_eff;

    always_comb begin
        shadow_fcw_d  = capture ? cfg_fcw      : shadow_fcw_q;
        shadow_poff_d = capture ? cfg_poff     : shadow_poff_q;
        fcw_act_d     = apply   ? shadow_fcw_q  : fcw_act_q;
        poff_act_d    = apply   ? shadow_poff_q : poff_act_q;
        fcw_eff       = fcw_act_d;
        poff_eff      = poff_act_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_fcw_q  <= '0;
            shadow_poff_q <= '0;
            fcw_act_q     <= '0;
            poff_act_q    <= '0;
        end else begin
            shadow_fcw_q  <= shadow_fcw_d;
            shadow_poff_q <= shadow_poff_d;
            fcw_act_q     <= fcw_act_d;
            poff_act_q    <= poff_act_d;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator and output datapath
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [A_width-1:0]   angle_q, angle_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic [15:0]          wrap_cnt_q, wrap_cnt_d;

    // One extra bit captures the carry out of the accumulator add.
    logic [ACC_WIDTH:0]   acc_sum;
    logic [A_width-1:0]   acc_top;

    assign acc_sum = {1'b0, acc_q} + {1'b0, fcw_eff};
    assign acc_top = acc_q[ACC_WIDTH-1 -: A_width];

    always_comb begin
        acc_d      = acc_q;
        angle_d    = angle_q;
        valid_d    = 1'b0;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            acc_d      = '0;
            angle_d    = '0;
            wrap_cnt_d = '0;
        end else if (en) begin
            // The sample reflects the accumulator before this add, so the
            // first sample after reset/clear is just the offset.
            angle_d    = acc_top + poff_eff;
            acc_d      = acc_sum[ACC_WIDTH-1:0];
            valid_d    = 1'b1;
            wrap_d     = acc_sum[ACC_WIDTH];
            wrap_cnt_d = wrap_cnt_q + 16'(acc_sum[ACC_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            angle_q    <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            angle_q    <= angle_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign angle_A     = angle_q;
    assign angle_valid = valid_q;
    assign wrap        = wrap_q;
    assign wrap_cnt    = wrap_cnt_q;

endmodule

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 Parameter ACC_WIDTH, default 32, sets the phase accumulator width in bits.
REQ-002 Parameter A_width, default 16, sets the output angle width; the block SHALL reject configurations where A_width > ACC_WIDTH (elaboration error).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  advance strobe; one output sample per cycle with en=1.
REQ-006 clr  input  1  synchronous clear of the accumulator and output state.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_ready  output  1  configuration can be accepted.
REQ-009 cfg_fcw  input  ACC_WIDTH  frequency control word (unsigned phase increment).
REQ-010 cfg_poff  input  A_width  phase offset added to the output angle.
REQ-011 angle_A  output  A_width  binary angle (full scale = 2*pi) for the downstream sine/cosine stage.
REQ-012 angle_valid  output  1  angle_A holds a new sample this cycle.
REQ-013 wrap  output  1  the accumulator add that produced the next sample carried out of ACC_WIDTH.
REQ-014 wrap_cnt  output  16  count of accumulator wraps, modulo 2^16.

Function
REQ-015 Registers: acc (ACC_WIDTH), fcw_act, poff_act, shadow fcw/poff, pending flag, and output registers angle_A, angle_valid, wrap, wrap_cnt.
REQ-016 Config FSM has two states, READY (pending=0) and PENDING (pending=1); cfg_ready SHALL equal ~pending combinationally.
REQ-017 In READY, cfg_valid=1 SHALL capture cfg_fcw/cfg_poff into the shadow registers and move to PENDING at the next edge; cfg_valid=0 SHALL leave the FSM in READY.
REQ-018 In PENDING, the first cycle with en=1 and clr=0 SHALL copy shadow to fcw_act/poff_act and return to READY; the new values SHALL be used by that same cycle's add and output.
REQ-019 While in PENDING, cfg_valid SHALL be ignored and the shadow registers SHALL hold their values.
REQ-020 A cycle with en=1 and clr=0 SHALL update angle_A <= acc[ACC_WIDTH-1 -: A_width] + poff (mod 2^A_width, truncation, no rounding), acc <= acc + fcw (mod 2^ACC_WIDTH), wrap <= carry-out of that add, and angle_valid <= 1; poff and fcw are the values in effect per REQ-018.
REQ-021 The latency from an en=1 cycle to the corresponding angle_valid=1 is 1 cycle; the first sample after reset or clr SHALL be the top bits of acc=0 plus poff.
REQ-022 On any edge where wrap is set to 1, wrap_cnt SHALL increment by 1 at that same edge, wrapping from 0xFFFF to 0x0000.
REQ-023 A cycle with en=0 and clr=0 SHALL hold acc, angle_A and wrap_cnt, and SHALL set angle_valid <= 0 and wrap <= 0.
REQ-024 clr=1 SHALL take priority over en and SHALL set acc, angle_A, wrap and wrap_cnt to 0 and angle_valid <= 0.
REQ-025 clr SHALL NOT affect fcw_act, poff_act, the shadow registers or the pending flag.
REQ-026 clr=1 in PENDING SHALL NOT apply the pending config; it applies at the next en=1, clr=0 cycle.
REQ-027 fcw=0 SHALL yield a constant angle_A=poff with angle_valid pulsing per en; wrap SHALL stay 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear acc, fcw_act, poff_act, the shadow registers, pending, angle_A, angle_valid, wrap and wrap_cnt to 0, making cfg_ready=1.
REQ-029 Deassertion of rst_n SHALL take effect at a clk edge; the first active cycle behaves as if acc=0.
REQ-030 Reset asserted in PENDING SHALL discard the pending configuration.

Verification (ACC_WIDTH=32, A_width=16)
REQ-031 Config fcw=0x4000_0000, poff=0, then en=1 continuously -> angle_A 0x0000, 0x4000, 0x8000, 0xC000, 0x0000...; wrap=1 alongside the 0xC000 sample; wrap_cnt=1 after 4 samples.
REQ-032 fcw=0x0001_0000, poff=0x8000 -> angle_A 0x8000, 0x8001, 0x8002, each 1 cycle after its en.
REQ-033 Config offered while pending (en=0) -> cfg_ready=0 and the second config is ignored; first en=1 applies the first config and cfg_ready returns to 1 on the next cycle.
REQ-034 clr=1 and en=1 in the same cycle mid-run -> next cycle angle_A=0, angle_valid=0, wrap_cnt=0; fcw unchanged, so the following en=1 gives angle_A=poff.
REQ-035 fcw=0xFFFF_FFFF for 0x10001 en cycles -> wrap_cnt wraps 0xFFFF to 0x0000; en gaps hold the count.
REQ-036 rst_n pulsed low mid-run with a config pending -> all outputs 0 immediately and cfg_ready=1; the pending fcw is never applied.
